// File: rtl/neural_pkg.sv
// Shared types and word formats for the neural frame packer.
// Holds FSM states, sync bytes and the buffered sample record.
package neural_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        SAMPLES,
        TRAILER
    } frame_state_e;

    localparam logic [7:0] SYNC_HDR = 8'hA5;
    localparam logic [7:0] SYNC_SMP = 8'hD0;
    localparam logic [7:0] SYNC_TRL = 8'h5A;

    // Fields are stored at their widest word-format size, zero-extended.
    typedef struct packed {
        logic [7:0]  ch;
        logic [15:0] data;
    } sample_t;

    function automatic logic [31:0] hdr_word(
        input logic [7:0]  cnt,
        input logic [15:0] seq
    );
        return {SYNC_HDR, cnt, seq};
    endfunction

    function automatic logic [31:0] smp_word(input sample_t s);
        return {SYNC_SMP, s.ch, s.data};
    endfunction

    function automatic logic [31:0] trl_word(
        input logic [7:0]  cnt,
        input logic [15:0] csum
    );
        return {SYNC_TRL, cnt, csum};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with full/empty flags.
// A push while full is legal when a pop happens in the same cycle.
module sample_fifo
    import neural_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic    sys_clk,
    input  logic    rst_n,
    input  logic    push,
    input  sample_t wr_sample,
    input  logic    pop,
    output sample_t rd_sample,
    output logic    full,
    output logic    empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sample_t       mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_sample = mem[rd_ptr[AW-1:0]];

    // Storage array; written only on an accepted push.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_sample;
        end
    end

    // Read/write pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/neural_frame_packer.sv
// Frames the aggregated sample stream into header/sample/trailer words.
// One frame per sweep, closed by count, channel wrap or idle timeout.
module neural_frame_packer
    import neural_pkg::*;
#(
    parameter int NUM_CHANNELS   = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int CH_ID_WIDTH    = 4,
    parameter int FIFO_DEPTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic [NUM_CHANNELS-1:0] channel_mask,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [CH_ID_WIDTH-1:0]  in_channel,
    input  logic                    in_valid,
    output logic [31:0]             out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    overflow_sticky,
    input  logic                    overflow_clr
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    frame_state_e state, state_n;

    logic [7:0]    exp_cnt, exp_cnt_n;
    logic [7:0]    sent_cnt, sent_cnt_n;
    logic [15:0]   csum, csum_n;
    logic [7:0]    last_ch, last_ch_n;
    logic [15:0]   seq, seq_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [31:0]   out_data_n;
    logic          out_valid_n;
    logic          out_last_n;
    logic [7:0]    mask_cnt;

    logic          load;
    logic          push;
    logic          pop;
    logic          drop;
    logic          full;
    logic          empty;
    sample_t       in_sample;
    sample_t       head;
    logic          close_cnt;
    logic          close_wrap;
    logic          close_tmo;

    assign in_sample.ch   = 8'(in_channel);
    assign in_sample.data = 16'(in_data);

    assign load = !out_valid || out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    assign close_cnt  = (exp_cnt != 8'd0) && (sent_cnt == exp_cnt);
    assign close_wrap = !empty && (sent_cnt != 8'd0) && (head.ch <= last_ch);
    assign close_tmo  = empty && (tmo >= TW'(TIMEOUT_CYCLES));

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .push      (push),
        .wr_sample (in_sample),
        .pop       (pop),
        .rd_sample (head),
        .full      (full),
        .empty     (empty)
    );

    // Number of enabled channels, latched as the expected count per frame.
    always_comb begin
        mask_cnt = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            mask_cnt = mask_cnt + 8'(channel_mask[i]);
        end
    end

    // Next-state, counter and output-word logic.
    always_comb begin
        state_n     = state;
        exp_cnt_n   = exp_cnt;
        sent_cnt_n  = sent_cnt;
        csum_n      = csum;
        last_ch_n   = last_ch;
        seq_n       = seq;
        tmo_n       = tmo;
        pop         = 1'b0;
        out_data_n  = out_data;
        out_valid_n = out_valid;
        out_last_n  = out_last;
        if (load) begin
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
        end
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_n    = HEADER;
                    exp_cnt_n  = mask_cnt;
                    sent_cnt_n = '0;
                    csum_n     = '0;
                    last_ch_n  = '0;
                    tmo_n      = '0;
                end
            end
            HEADER: begin
                if (load) begin
                    out_data_n  = hdr_word(exp_cnt, seq);
                    out_valid_n = 1'b1;
                    state_n     = SAMPLES;
                end
            end
            SAMPLES: begin
                if (close_cnt || close_wrap || close_tmo) begin
                    state_n = TRAILER;
                end else if (!empty) begin
                    tmo_n = '0;
                    if (load) begin
                        pop         = 1'b1;
                        out_data_n  = smp_word(head);
                        out_valid_n = 1'b1;
                        sent_cnt_n  = sent_cnt + 8'd1;
                        csum_n      = csum + head.data;
                        last_ch_n   = head.ch;
                    end
                end else begin
                    tmo_n = tmo + TW'(1);
                end
            end
            TRAILER: begin
                if (out_valid && out_last) begin
                    if (out_ready) begin
                        state_n = IDLE;
                        seq_n   = seq + 16'd1;
                    end
                end else if (load) begin
                    out_data_n  = trl_word(sent_cnt, csum);
                    out_valid_n = 1'b1;
                    out_last_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters and the output word register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            exp_cnt   <= '0;
            sent_cnt  <= '0;
            csum      <= '0;
            last_ch   <= '0;
            seq       <= '0;
            tmo       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_n;
            exp_cnt   <= exp_cnt_n;
            sent_cnt  <= sent_cnt_n;
            csum      <= csum_n;
            last_ch   <= last_ch_n;
            seq       <= seq_n;
            tmo       <= tmo_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            out_last  <= out_last_n;
        end
    end

    // Sticky drop flag; a new drop beats a simultaneous clear.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_sticky <= 1'b0;
        end else if (drop) begin
            overflow_sticky <= 1'b1;
        end else if (overflow_clr) begin
            overflow_sticky <= 1'b0;
        end
    end

endmodule
